// File: rtl/aes_pkg.sv
// Shared AES definitions: word width, arbiter defaults, lock-counter width
// and the byte substitution used by the S-box.
package aes_pkg;

   localparam int WORD_W       = 32;
   localparam int NUM_REQ_DEF  = 4;
   localparam int MAX_LOCK_DEF = 4;
   localparam int LOCK_CNT_W   = 4;

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = '0;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // Inverse as a^254 (square-and-multiply); 0 maps to 0 without a special case.
   function automatic logic [7:0] sbox_byte(input logic [7:0] a);
      logic [7:0] sq;
      logic [7:0] inv;
      sq  = a;
      inv = 8'h01;
      for (int i = 1; i < 8; i++) begin
         sq  = gf_mul(sq, sq);
         inv = gf_mul(inv, sq);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                 ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES S-box applied bytewise to two 32-bit words.
module aes_sbox
   import aes_pkg::*;
(
   input  logic [WORD_W-1:0] w1_i,
   input  logic [WORD_W-1:0] w2_i,
   output logic [WORD_W-1:0] w1_o,
   output logic [WORD_W-1:0] w2_o
);

   for (genvar b = 0; b < WORD_W / 8; b++) begin : g_byte
      assign w1_o[b*8 +: 8] = sbox_byte(w1_i[b*8 +: 8]);
      assign w2_o[b*8 +: 8] = sbox_byte(w2_i[b*8 +: 8]);
   end

endmodule

// File: rtl/aes_sbox_arbiter.sv
// Round-robin arbiter with bounded lock bursts sharing one S-box among
// NUM_REQ requesters; substituted words are registered, one cycle latency.
module aes_sbox_arbiter
   import aes_pkg::*;
#(
   parameter int NUM_REQ  = NUM_REQ_DEF,
   parameter int MAX_LOCK = MAX_LOCK_DEF
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ-1:0]        req_lock,
   input  logic [NUM_REQ*WORD_W-1:0] req_w1,
   input  logic [NUM_REQ*WORD_W-1:0] req_w2,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic [NUM_REQ-1:0]        rsp_valid,
   output logic [WORD_W-1:0]         rsp_w1,
   output logic [WORD_W-1:0]         rsp_w2,
   output logic                      busy
);

   localparam int                    IDX_W    = $clog2(NUM_REQ);
   localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_REQ - 1);
   localparam logic [LOCK_CNT_W-1:0] LOCK_MAX = LOCK_CNT_W'(MAX_LOCK);

   logic [IDX_W-1:0]      last_grant_q, last_grant_d;
   logic [IDX_W-1:0]      lock_owner_q, lock_owner_d;
   logic                  lock_active_q, lock_active_d;
   logic [LOCK_CNT_W-1:0] lock_cnt_q, lock_cnt_d;
   logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
   logic [WORD_W-1:0]     rsp_w1_q, rsp_w1_d;
   logic [WORD_W-1:0]     rsp_w2_q, rsp_w2_d;

   logic                  lock_hold;
   logic                  gnt_any;
   logic [IDX_W-1:0]      gnt_idx;
   logic [NUM_REQ-1:0]    gnt_oh;
   logic [LOCK_CNT_W-1:0] cnt_next;
   logic [WORD_W-1:0]     mux_w1, mux_w2, sub_w1, sub_w2;

   assign lock_hold = lock_active_q & req_valid[lock_owner_q] & req_lock[lock_owner_q];

   // Scan offsets high to low so the nearest requester after last_grant wins.
   always_comb begin : p_grant
      int cand;
      // NOTE: every always_comb output gets a default first, so no path can infer a latch.
      cand    = 0;
      gnt_any = 1'b0;
      gnt_idx = '0;
      if (lock_hold) begin
         gnt_any = 1'b1;
         gnt_idx = lock_owner_q;
      end else begin
         for (int off = NUM_REQ; off >= 1; off--) begin
            cand = (int'(last_grant_q) + off) % NUM_REQ;
            if (req_valid[IDX_W'(cand)]) begin
               gnt_any = 1'b1;
               gnt_idx = IDX_W'(cand);
            end
         end
      end
      if (reset) gnt_any = 1'b0;
   end

   always_comb begin
      gnt_oh = '0;
      if (gnt_any) gnt_oh[gnt_idx] = 1'b1;
   end

   always_comb begin
      mux_w1 = '0;
      mux_w2 = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         mux_w1 = mux_w1 | (req_w1[i*WORD_W +: WORD_W] & {WORD_W{gnt_oh[i]}});
         mux_w2 = mux_w2 | (req_w2[i*WORD_W +: WORD_W] & {WORD_W{gnt_oh[i]}});
      end
   end

   aes_sbox u_sbox (
      .w1_i (mux_w1),
      .w2_i (mux_w2),
      .w1_o (sub_w1),
      .w2_o (sub_w2)
   );

   // A fresh lock grant counts as the first of the burst.
   assign cnt_next = lock_hold ? lock_cnt_q + LOCK_CNT_W'(1) : LOCK_CNT_W'(1);

   always_comb begin
      last_grant_d  = last_grant_q;
      lock_owner_d  = lock_owner_q;
      lock_active_d = 1'b0;
      lock_cnt_d    = '0;
      rsp_valid_d   = gnt_oh;
      rsp_w1_d      = rsp_w1_q;
      rsp_w2_d      = rsp_w2_q;
      if (gnt_any) begin
         last_grant_d = gnt_idx;
         rsp_w1_d     = sub_w1;
         rsp_w2_d     = sub_w2;
         if (req_lock[gnt_idx] && (cnt_next < LOCK_MAX)) begin
            lock_active_d = 1'b1;
            lock_cnt_d    = cnt_next;
            lock_owner_d  = gnt_idx;
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         last_grant_q  <= LAST_IDX;
         lock_owner_q  <= '0;
         lock_active_q <= 1'b0;
         lock_cnt_q    <= '0;
         rsp_valid_q   <= '0;
         rsp_w1_q      <= '0;
         rsp_w2_q      <= '0;
      end else begin
         last_grant_q  <= last_grant_d;
         lock_owner_q  <= lock_owner_d;
         lock_active_q <= lock_active_d;
         lock_cnt_q    <= lock_cnt_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_w1_q      <= rsp_w1_d;
         rsp_w2_q      <= rsp_w2_d;
      end
   end

   assign req_ready = gnt_oh;
   assign rsp_valid = rsp_valid_q;
   assign rsp_w1    = rsp_w1_q;
   assign rsp_w2    = rsp_w2_q;
   assign busy      = lock_active_q;

endmodule
